// File: rtl/bcd_sub_seq.sv
// Digit-serial packed-BCD subtractor: one digit per clock, LSD first, with a
// ten's-complement pass that turns a wrapped result into sign-magnitude form.
module bcd_sub_seq #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [4*DIGITS-1:0] x,
   input  logic [4*DIGITS-1:0] y,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] d,
   output logic                neg,
   output logic                invalid
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, SUB, COMP, DONE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            borrow_q, borrow_d;
   logic [W-1:0]    x_q, x_d, y_q, y_d, d_q, d_d;
   logic            neg_q, neg_d, inv_q, inv_d;

   logic [3:0]      op_a, op_b;
   logic [4:0]      step;
   logic            last;

   function automatic logic [3:0] get_dig(input logic [W-1:0] v, input logic [IW-1:0] i);
      logic [3:0] r;
      r = 4'd0;
      for (int k = 0; k < DIGITS; k++)
         if (IW'(k) == i) r = v[4*k +: 4];
      return r;
   endfunction

   function automatic logic [W-1:0] put_dig(input logic [W-1:0] v, input logic [IW-1:0] i,
                                            input logic [3:0] r);
      logic [W-1:0] o;
      o = v;
      for (int k = 0; k < DIGITS; k++)
         if (IW'(k) == i) o[4*k +: 4] = r;
      return o;
   endfunction

   // Returns {borrow_out, digit}. Operands are <= 9, so t stays in -10..9 and
   // fits 5-bit signed; adding 10 modulo 16 on the low nibble is the correction.
   function automatic logic [4:0] dig_sub(input logic [3:0] a, input logic [3:0] b,
                                          input logic bin);
      logic [4:0] t;
      t = {1'b0, a} - {1'b0, b} - {4'b0, bin};
      if (t[4]) return {1'b1, t[3:0] + 4'd10};
      else      return {1'b0, t[3:0]};
   endfunction

   function automatic logic has_bad(input logic [W-1:0] a, input logic [W-1:0] b);
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < DIGITS; k++)
         if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) bad = 1'b1;
      return bad;
   endfunction

   assign last = (idx_q == IW'(DIGITS - 1));

   // COMP reuses the same digit step as 0 - r_i - borrow.
   assign op_a = (state_q == COMP) ? 4'd0 : get_dig(x_q, idx_q);
   assign op_b = (state_q == COMP) ? get_dig(d_q, idx_q) : get_dig(y_q, idx_q);
   assign step = dig_sub(op_a, op_b, borrow_q);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      borrow_d = borrow_q;
      x_d      = x_q;
      y_d      = y_q;
      d_d      = d_q;
      neg_d    = neg_q;
      inv_d    = inv_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               x_d   = x;
               y_d   = y;
               neg_d = 1'b0;
               if (has_bad(x, y)) begin
                  inv_d   = 1'b1;
                  d_d     = '0;
                  state_d = DONE;
               end else begin
                  inv_d    = 1'b0;
                  borrow_d = 1'b0;
                  idx_d    = '0;
                  state_d  = SUB;
               end
            end
         end
         SUB: begin
            d_d      = put_dig(d_q, idx_q, step[3:0]);
            borrow_d = step[4];
            idx_d    = idx_q + 1'b1;
            if (last) begin
               idx_d    = '0;
               borrow_d = 1'b0;
               neg_d    = step[4];
               state_d  = step[4] ? COMP : DONE;
            end
         end
         COMP: begin
            d_d      = put_dig(d_q, idx_q, step[3:0]);
            borrow_d = step[4];
            idx_d    = idx_q + 1'b1;
            if (last) begin
               idx_d    = '0;
               borrow_d = 1'b0;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         d_q      <= '0;
         neg_q    <= 1'b0;
         inv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         borrow_q <= borrow_d;
         x_q      <= x_d;
         y_q      <= y_d;
         d_q      <= d_d;
         neg_q    <= neg_d;
         inv_q    <= inv_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign d       = d_q;
   assign neg     = neg_q;
   assign invalid = inv_q;

endmodule

// File: doc/bcd_sub_seq.md
Name: bcd_sub_seq

Overview:
- Digit-serial, multi-digit BCD subtractor with a start/done handshake.
- Subtracts one packed-BCD operand from another, least-significant digit first, one digit per clock.
- Each digit step applies the 4-bit digit-subtract-and-correct operation from the arithmetic block library.
- Returns sign-magnitude BCD, so downstream comparator and code-converter stages receive a valid packed-BCD magnitude plus a sign flag.

Parameters:
- DIGITS, 4, number of BCD digits per operand (range 1..8).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- x  input  4*DIGITS  minuend, packed BCD, digit 0 = bits [3:0]
- y  input  4*DIGITS  subtrahend, packed BCD
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse when the result is valid
- d  output  4*DIGITS  magnitude |x-y|, packed BCD
- neg  output  1  1 when x < y
- invalid  output  1  1 when any digit of x or y is greater than 9

Behaviour:
- Reset (asynchronous, any state, mid-operation included):
  - state = IDLE; busy = done = neg = invalid = 0; d = 0.
  - Internal borrow, digit index and operand registers are cleared.
  - No done pulse is produced for an aborted operation.
- States: IDLE, SUB, COMP, DONE.
- IDLE:
  - On start=1, latch x and y and check every nibble.
  - If any nibble is greater than 9: set invalid=1, d=0, neg=0, then go to DONE.
  - Otherwise: clear invalid, set borrow=0 and index=0, then go to SUB.
- SUB, one digit per cycle at digit index i:
  - t = x_i - y_i - borrow, computed as 5-bit signed.
  - If t < 0: r_i = t + 10 and borrow = 1. Otherwise: r_i = t and borrow = 0.
  - r_i is written into d at digit i.
  - After digit DIGITS-1: if borrow = 0, set neg=0 and go to DONE. If borrow = 1, set neg=1, reset borrow=0 and index=0, and go to COMP.
- COMP, ten's-complement pass that converts the wrapped result to a magnitude:
  - Per cycle: t = 0 - r_i - borrow, with the same +10 correction and borrow rule as SUB. The corrected digit overwrites d at digit i.
  - After digit DIGITS-1, go to DONE. The final borrow from this pass is discarded.
- DONE: done=1 for exactly this one cycle, busy=1, then go to IDLE.
- Latency, counted in cycles from the start-sampling edge to the cycle in which done is high:
  - valid operands with x ≥ y: DIGITS+1
  - valid operands with x < y: 2*DIGITS+1
  - invalid operands: 1
- Output timing:
  - d holds intermediate digits while busy. It is guaranteed valid only in the done cycle and afterwards.
  - d, neg and invalid hold their values until the next accepted start.
- start is ignored while busy=1, including the DONE cycle. There is no queuing. x and y may change freely after the accepting edge.
- Zero result: x = y gives d = 0 and neg = 0. A negative zero is never produced.
- Wrap-around: the raw SUB result is (x - y) mod 10^DIGITS. The COMP pass is what yields the true magnitude.

Test Plan:
- DIGITS=4, x=0x0935, y=0x0426, start pulse → done on cycle 5; d=0x0509, neg=0, invalid=0; busy high cycles 1–5.
- x=0x0426, y=0x0935 → done on cycle 9; d=0x0509, neg=1. Also x=0x0000, y=0x0001 → d=0x0001, neg=1.
- Borrow-ripple cases: x=0x1000, y=0x0001 → d=0x0999, neg=0. x=0x9999, y=0x9999 → d=0x0000, neg=0, done on cycle 5.
- x=0x09A5, y=0x0001 → done on cycle 1; invalid=1, d=0x0000, neg=0. The next valid start clears invalid.
- Start with x=0x0426, y=0x0935; assert rst at cycle 3 → all outputs 0 immediately, no done pulse. A fresh start after rst release completes normally.
- Start re-pulsed during busy cycles 2–4 with different operands → ignored; the result matches the first operands, and exactly one done pulse occurs.
